ws2812b_rx: RTL and testbench
=============================

Name: ws2812b_rx

Overview:
Receive-side counterpart of the WS2812B LED driver. Decodes the single-wire WS2812B NRZ stream the way a real pixel does:
- measures each high pulse and decodes it as a bit;
- captures the first 24 bits (GRB, MSB first) of every frame;
- regenerates all later bits on dout;
- detects the RET/latch low period.

It emulates a pixel on the Basys 3 (100 MHz) so the LED transmitter can be checked in loopback and daisy-chained against further decoders.

Parameters:
THRESH, 60, high-pulse length in clk cycles at or above which a bit decodes as 1 (0.6 us)
MIN_HIGH, 15, shortest legal high pulse in cycles; shorter is a glitch error
MAX_HIGH, 110, longest legal high pulse in cycles; longer is an error
RET_CYCLES, 5000, low length in cycles that ends a frame (50 us)

Ports:
clk  input  1  system clock, 100 MHz
reset  input  1  synchronous, active-high reset
din  input  1  asynchronous serial WS2812B stream
pixel_data  output  24  last captured pixel word, {G[7:0],R[7:0],B[7:0]}, bit 23 = first received
pixel_valid  output  1  one-cycle pulse when pixel_data is updated
dout  output  1  regenerated stream of bits 25..N of the frame; 0 otherwise
frame_done  output  1  one-cycle pulse when RET is detected after a frame
err  output  1  one-cycle pulse on a protocol error
bit_count  output  5  number of bits captured in the current pixel word, 0..24

Behaviour:
- Reset (clk, reset synchronous, active-high) values:
  - pixel_data=0, pixel_valid=0, dout=0, frame_done=0, err=0, bit_count=0;
  - state=WAIT_RET, counters=0, synchronizer flops=0.
- Input sync: din passes through 2 flops to give s_din. All timing is measured on s_din, and all latencies below are relative to the s_din transition.
- Counters: high_cnt and low_cnt are 16 bits, saturate at RET_CYCLES and never wrap.
- States and transitions:
  - WAIT_RET:
    - low_cnt counts cycles with s_din=0 and clears whenever s_din=1.
    - When low_cnt reaches RET_CYCLES, go to IDLE.
    - Data arriving before that is ignored. This aligns to frame boundaries after reset or error.
  - IDLE: armed with bit_count=0. s_din=1 → HIGH with high_cnt=1.
  - HIGH:
    - high_cnt increments while s_din=1.
    - high_cnt > MAX_HIGH → err pulse, go to WAIT_RET.
    - On first s_din=0 with high_cnt < MIN_HIGH → err pulse, go to WAIT_RET.
    - On first s_din=0 otherwise: the bit is (high_cnt >= THRESH). Shift it into the capture register MSB first, increment bit_count, go to LOW with low_cnt=1.
  - LOW:
    - s_din=1 → HIGH.
    - low_cnt reaching RET_CYCLES with 0 < bit_count < 24 → err pulse, pixel_data unchanged, go to IDLE with bit_count=0.
  - 24th bit: when the 24th bit is decoded, pixel_data loads the capture register and pixel_valid pulses in the next cycle. The state goes to PASS instead of LOW.
  - PASS:
    - dout is registered s_din (one cycle after s_din, three cycles after din).
    - low_cnt tracks s_din=0 runs.
    - When low_cnt reaches RET_CYCLES: frame_done pulses for one cycle, dout=0, bit_count=0, go to IDLE.
    - No timing checks in PASS; downstream decoders check their own bits.
- dout is 0 in every state except PASS, so the first 24 bits are never forwarded.
- pixel_data holds its value until the next complete 24-bit capture. Errors and partial frames never modify it.
- bit_count is readable live. It stays at 24 during PASS and clears on return to IDLE.
- A frame of exactly 24 bits behaves as follows: PASS is entered with s_din low, RET elapses, frame_done pulses, dout stays 0 throughout.
- Simultaneous events: reset overrides everything. err and pixel_valid are never asserted in the same cycle.
- Reset mid-frame: all state clears immediately. The rest of the frame is ignored until a full RET_CYCLES low is seen.

Test Plan:
- Nominal single pixel: after ≥RET low, send 0xA53C0F. Timing: 1 = 80 high/45 low, 0 = 40 high/85 low; then 5000 low. Required: one pixel_valid with pixel_data=0xA53C0F, exactly one frame_done, dout=0 throughout, err never asserts.
- Chain forwarding: send 48 bits, 0x123456 then 0xFF00AA. Required: pixel_data=0x123456 with a single pixel_valid. dout replays only bits 25..48 with identical pulse widths, delayed 3 cycles from din. frame_done pulses after RET.
- Threshold boundary: one 24-bit frame with bit 23 high for 59 cycles and bit 22 high for 60 cycles, rest 0. Required: pixel_data=0x400000.
- Glitch and overlong pulses: a 10-cycle high in bit 5 → err pulses; no pixel_valid until a later clean frame following ≥RET low decodes correctly. A 120-cycle high behaves the same way.
- Partial frame: 12 bits then 5000 low. Required: err pulses once, pixel_data keeps its previous value, bit_count returns to 0, the next full frame decodes correctly.
- Reset mid-frame: assert reset after bit 10. Required: all outputs 0 next cycle. Remaining bits are ignored with no pixel_valid. After ≥RET low, a new frame 0x00FF00 decodes correctly.

Source files
------------

// File: rtl/ws2812b_rx.sv
// ws2812b_rx: WS2812B pixel emulator; decodes the first 24 bits of each frame and regenerates the remaining bits on dout.
module ws2812b_rx #(
    parameter int THRESH     = 60,
    parameter int MIN_HIGH   = 15,
    parameter int MAX_HIGH   = 110,
    parameter int RET_CYCLES = 5000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        din,
    output logic [23:0] pixel_data,
    output logic        pixel_valid,
    output logic        dout,
    output logic        frame_done,
    output logic        err,
    output logic [4:0]  bit_count
);
    localparam logic [15:0] RET  = 16'(RET_CYCLES);
    localparam logic [15:0] THR  = 16'(THRESH);
    localparam logic [15:0] MINH = 16'(MIN_HIGH);
    localparam logic [15:0] MAXH = 16'(MAX_HIGH);

    typedef enum logic [2:0] {WAIT_RET, IDLE, HIGH, LOW, PASS} state_t;
    state_t state;

    logic        s1, s_din;
    logic [15:0] high_cnt, low_cnt, low_inc, high_inc;
    logic [22:0] cap;
    logic [23:0] cap_next;
    logic        low_ret;

    assign low_inc  = (low_cnt >= RET) ? RET : low_cnt + 16'd1;
    assign high_inc = (high_cnt >= RET) ? RET : high_cnt + 16'd1;
    assign low_ret  = !s_din && (low_inc >= RET);
    assign cap_next = {cap, high_cnt >= THR};

    always_ff @(posedge clk) begin
        if (reset) begin
            s1          <= 1'b0;
            s_din       <= 1'b0;
            state       <= WAIT_RET;
            high_cnt    <= '0;
            low_cnt     <= '0;
            cap         <= '0;
            pixel_data  <= '0;
            pixel_valid <= 1'b0;
            dout        <= 1'b0;
            frame_done  <= 1'b0;
            err         <= 1'b0;
            bit_count   <= '0;
        end else begin
            s1          <= din;
            s_din       <= s1;
            pixel_valid <= 1'b0;
            frame_done  <= 1'b0;
            err         <= 1'b0;
            dout        <= 1'b0;
            case (state)
                WAIT_RET: begin
                    low_cnt <= s_din ? '0 : low_inc;
                    if (low_ret) state <= IDLE;
                end
                IDLE: begin
                    bit_count <= '0;
                    if (s_din) begin
                        high_cnt <= 16'd1;
                        state    <= HIGH;
                    end
                end
                HIGH: begin
                    if (s_din) begin
                        high_cnt <= high_inc;
                        if (high_cnt >= MAXH) begin
                            err       <= 1'b1;
                            bit_count <= '0;
                            low_cnt   <= '0;
                            state     <= WAIT_RET;
                        end
                    end else if (high_cnt < MINH) begin
                        err       <= 1'b1;
                        bit_count <= '0;
                        low_cnt   <= '0;
                        state     <= WAIT_RET;
                    end else begin
                        cap       <= cap_next[22:0];
                        bit_count <= bit_count + 5'd1;
                        low_cnt   <= 16'd1;
                        // 24th bit completes the pixel; everything after it is forwarded
                        if (bit_count == 5'd23) begin
                            pixel_data  <= cap_next;
                            pixel_valid <= 1'b1;
                            state       <= PASS;
                        end else begin
                            state <= LOW;
                        end
                    end
                end
                LOW: begin
                    if (s_din) begin
                        high_cnt <= 16'd1;
                        state    <= HIGH;
                    end else begin
                        low_cnt <= low_inc;
                        if (low_ret) begin
                            err       <= 1'b1;
                            bit_count <= '0;
                            state     <= IDLE;
                        end
                    end
                end
                PASS: begin
                    low_cnt <= s_din ? '0 : low_inc;
                    dout    <= s_din;
                    if (low_ret) begin
                        frame_done <= 1'b1;
                        dout       <= 1'b0;
                        bit_count  <= '0;
                        state      <= IDLE;
                    end
                end
                default: state <= WAIT_RET;
            endcase
        end
    end
endmodule

// File: tb/tb_ws2812b_rx.sv
// tb_ws2812b_rx: directed frames with a scoreboard of expected pixel/frame/error events and a dout replay checker.
module tb_ws2812b_rx;
    logic        clk = 1'b0, reset = 1'b1, din = 1'b0;
    logic [23:0] pixel_data;
    logic        pixel_valid, dout, frame_done, err;
    logic [4:0]  bit_count;

    always #5 clk = ~clk;

    ws2812b_rx dut (
        .clk(clk), .reset(reset), .din(din), .pixel_data(pixel_data),
        .pixel_valid(pixel_valid), .dout(dout), .frame_done(frame_done),
        .err(err), .bit_count(bit_count)
    );

    typedef struct packed {
        logic [1:0]  kind;
        logic [23:0] data;
    } ev_t;
    localparam logic [1:0] K_PIX = 2'd0, K_FRM = 2'd1, K_ERR = 2'd2;

    ev_t sb[$];
    int  n_cmp = 0, n_bad = 0, dout_bad = 0, dout_high = 0, h0;
    logic fwd = 1'b0, d1 = 1'b0, d2 = 1'b0, d3 = 1'b0, f1 = 1'b0, f2 = 1'b0, f3 = 1'b0;

    // din and the forward flag delayed three clocks give the required dout
    always @(posedge clk) begin
        d1 <= din; d2 <= d1; d3 <= d2;
        f1 <= fwd; f2 <= f1; f3 <= f2;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [1:0] k, input logic [23:0] d);
        ev_t e;
        e.kind = k;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic pop_ev(input logic [1:0] k);
        ev_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_event: got kind %0d, expected none", k);
        end else begin
            e = sb.pop_front();
            chk("event_kind", 32'(k), 32'(e.kind));
            if (k == K_PIX) chk("pixel_data_on_valid", 32'(pixel_data), 32'(e.data));
        end
    endtask

    task automatic hold(input logic v, input int n);
        din = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_pulse(input int hi, input int lo, input logic f);
        fwd = f;
        hold(1'b1, hi);
        hold(1'b0, lo);
    endtask

    task automatic send_bits(input logic [23:0] w, input int n, input int base);
        for (int i = 0; i < n; i++)
            send_pulse(w[n-1-i] ? 80 : 40, w[n-1-i] ? 45 : 85, (base + i) >= 24);
        fwd = 1'b0;
    endtask

    task automatic frame_end(input string name);
        hold(1'b0, 5100);
        chk({name, "_events_pending"}, 32'(sb.size()), 0);
        chk({name, "_dout_bad_cycles"}, 32'(dout_bad), 0);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_pixel_data"}, 32'(pixel_data), 0);
        chk({name, "_pixel_valid"}, 32'(pixel_valid), 0);
        chk({name, "_dout"}, 32'(dout), 0);
        chk({name, "_frame_done"}, 32'(frame_done), 0);
        chk({name, "_err"}, 32'(err), 0);
        chk({name, "_bit_count"}, 32'(bit_count), 0);
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                if (pixel_valid || err) chk("pv_err_exclusive", 32'(pixel_valid & err), 0);
                if (pixel_valid) pop_ev(K_PIX);
                if (err) pop_ev(K_ERR);
                if (frame_done) pop_ev(K_FRM);
                if (dout !== (f3 ? d3 : 1'b0)) dout_bad++;
                if (dout === 1'b1) dout_high++;
            end
        join_none

        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b0;
        hold(1'b0, 5100);

        push(K_PIX, 24'hA53C0F); push(K_FRM, 0);
        send_bits(24'hA53C0F, 24, 0);
        chk("nominal_bit_count", 32'(bit_count), 24);
        frame_end("nominal");
        chk("nominal_dout_high", 32'(dout_high), 0);
        chk("nominal_bit_count_after", 32'(bit_count), 0);

        push(K_PIX, 24'h123456); push(K_FRM, 0);
        send_bits(24'h123456, 24, 0);
        chk("chain_bit_count", 32'(bit_count), 24);
        chk("chain_pixel", 32'(pixel_data), 32'h123456);
        h0 = dout_high;
        send_bits(24'hFF00AA, 24, 24);
        frame_end("chain");
        chk("chain_dout_high_cycles", 32'(dout_high - h0), 1440);
        chk("chain_pixel_kept", 32'(pixel_data), 32'h123456);

        push(K_PIX, 24'h400000); push(K_FRM, 0);
        send_pulse(59, 66, 1'b0);
        send_pulse(60, 65, 1'b0);
        send_bits(24'h000000, 22, 2);
        frame_end("threshold");

        push(K_ERR, 0);
        send_bits(24'hF, 4, 0);
        send_pulse(10, 100, 1'b0);
        frame_end("glitch");
        chk("glitch_bit_count", 32'(bit_count), 0);

        push(K_ERR, 0);
        send_bits(24'h5, 4, 0);
        send_pulse(120, 100, 1'b0);
        frame_end("overlong");
        chk("overlong_pixel_kept", 32'(pixel_data), 32'h400000);

        push(K_PIX, 24'h5AC33C); push(K_FRM, 0);
        send_bits(24'h5AC33C, 24, 0);
        frame_end("clean");

        push(K_ERR, 0);
        send_bits(24'hABC, 12, 0);
        chk("partial_bit_count_live", 32'(bit_count), 12);
        frame_end("partial");
        chk("partial_bit_count", 32'(bit_count), 0);
        chk("partial_pixel_kept", 32'(pixel_data), 32'h5AC33C);

        send_bits(24'h2AD, 10, 0);
        chk("midreset_bit_count", 32'(bit_count), 10);
        reset = 1'b1;
        @(negedge clk);
        chk_all_zero("midreset");
        reset = 1'b0;
        send_bits(24'h3FFF, 14, 10);
        frame_end("midreset_ignore");

        push(K_PIX, 24'h00FF00); push(K_FRM, 0);
        send_bits(24'h00FF00, 24, 0);
        frame_end("after_reset");
        chk("after_reset_pixel", 32'(pixel_data), 32'h00FF00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
